gfifo_rd_ctrl: RTL
==================

Name: gfifo_rd_ctrl

Overview:
Buffered read-side stage that feeds the gated-FIFO read-count observer. It accepts words from a producer over a valid/ready handshake and holds them in a DEPTH-entry circular buffer. It drains them to a consumer over a second valid/ready handshake. It maintains the free-running 64-bit rdCnt (and wrCnt) that the downstream observer samples every cycle.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, buffer entries; power of two, >=2
CNT_W, 64, width of rdCnt/wrCnt; fixed at 64 to match the observer input
LVL_W, $clog2(DEPTH)+1, occupancy width (derived; not overridable)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous buffer clear
wr_valid  in  1  producer word valid
wr_data  in  WIDTH  producer word
wr_ready  out  1  buffer can accept a word
rd_valid  out  1  head word valid
rd_data  out  WIDTH  head word
rd_ready  in  1  consumer accepts head word
level  out  LVL_W  current occupancy, 0..DEPTH
full  out  1  level==DEPTH
empty  out  1  level==0
rdCnt  out  CNT_W  total words popped since reset
wrCnt  out  CNT_W  total words pushed since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, all state is cleared immediately and held cleared.
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, level=0, full=0, empty=1, rdCnt=0, wrCnt=0.
- Push and pop:
  - push = wr_valid & wr_ready.
  - pop = rd_valid & rd_ready.
  - Both are evaluated on the same edge.
- wr_ready = !full. It is a pure function of registered state, with no combinational path from rd_ready. A push while full is not possible, even if a pop occurs the same cycle.
- rd_valid = !empty. rd_data is the entry at the read pointer and is valid whenever rd_valid is high. It is held stable while rd_valid & !rd_ready.
- Latency: a word pushed at edge N is presented on rd_valid/rd_data after edge N. This is a minimum 1-cycle push-to-pop latency and there is no bypass.
- Pointers:
  - wptr and rptr are LVL_W bits wide; the MSB is the wrap bit and the memory index is the low bits.
  - full when the low bits are equal and the MSBs differ; empty when all bits are equal.
  - level = wptr - rptr, modulo 2^LVL_W.
- Simultaneous push and pop: level is unchanged and both pointers advance. When level==1, the popped word leaves and the pushed word becomes the head on the next cycle.
- Counters:
  - rdCnt += 1 on each pop; wrCnt += 1 on each push.
  - Both are unsigned and wrap modulo 2^64 with no saturation.
  - Invariant outside flush history: wrCnt - rdCnt == level, modulo 2^64.
- Flush (synchronous):
  - On the edge where flush=1, both pointers are set to 0 and contents are discarded. Outputs read level=0 and empty=1 after that edge.
  - Flush has priority: a push or pop in the same cycle is ignored and does not increment the counters.
  - rdCnt and wrCnt are NOT cleared. After a flush, the invariant above becomes wrCnt - rdCnt == level + discarded words.
- Reset mid-operation: rst asserted during any push or pop aborts it. The entire state returns to reset values asynchronously, and no partial count update is kept.
- Memory contents are not reset. Only pointers, counters and the rd_data output register are reset; rd_data is driven 0 while empty.
- There is no underflow or overflow path: the handshake rules make both impossible. The bench checks this with assertions.

Decomposition:
- Package gfifo_pkg: parameter defaults, the cnt_t typedef (logic [63:0]), and the ptr-width function (clog2+1).
- Sub-module gfifo_ram: a DEPTH x WIDTH register array with a single write port and an asynchronous read port.
- Pointer logic, counters and flags stay in the top level.

Test Plan:
- Reset then idle → wr_ready=1, rd_valid=0, level=0, rdCnt=wrCnt=0 every cycle.
- Push 16 words 0x00..0x0F with rd_ready=0 → full=1 and wr_ready=0 after the 16th; wrCnt=16. A 17th wr_valid is not accepted and wrCnt stays 16.
- Then rd_ready=1 for 16 cycles → rd_data sequence 0x00..0x0F in order; rdCnt=16, empty=1; rd_valid drops on the cycle after the last pop.
- Continuous push and pop with level=1 for 100 cycles → level stays 1; rdCnt and wrCnt each grow by 100; data order is preserved; pointers wrap 6 times without error.
- Flush at level=5, asserted together with a push and a pop → level=0 and empty=1 next cycle; rdCnt and wrCnt unchanged from the prior cycle.
- Force rdCnt to 0xFFFF_FFFF_FFFF_FFFF and pop once → rdCnt=0. Separately, assert rst mid-burst → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/gfifo_pkg.sv
// Shared defaults and helpers for the gated-FIFO read-side stage.
package gfifo_pkg;

  localparam int GFIFO_WIDTH_DEF = 32;
  localparam int GFIFO_DEPTH_DEF = 16;
  localparam int GFIFO_CNT_W     = 64;

  typedef logic [63:0] cnt_t;

  // Pointer width carries one extra wrap bit above the memory index.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gfifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module gfifo_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] memQ [DEPTH];

  // Storage is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (we_i) begin
      memQ[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = memQ[raddr_i];

endmodule

// File: rtl/gfifo_rd_ctrl.sv
// Buffered read-side stage: valid/ready in, valid/ready out, plus free-running push/pop counters.
module gfifo_rd_ctrl
  import gfifo_pkg::*;
#(
  parameter int  WIDTH = GFIFO_WIDTH_DEF,
  parameter int  DEPTH = GFIFO_DEPTH_DEF,
  parameter int  CNT_W = GFIFO_CNT_W,
  localparam int LVL_W = ptrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] rdCnt,
  output logic [CNT_W-1:0] wrCnt
);

  localparam int ADDR_W = LVL_W - 1;

  logic [LVL_W-1:0] wptrQ, wptrD;
  logic [LVL_W-1:0] rptrQ, rptrD;
  logic [CNT_W-1:0] rdCntQ, rdCntD;
  logic [CNT_W-1:0] wrCntQ, wrCntD;
  logic [WIDTH-1:0] rdDataQ, rdDataD;
  logic [WIDTH-1:0] ramRdata;
  logic             push, pop, ramWe;

  assign full  = (wptrQ[LVL_W-1] != rptrQ[LVL_W-1]) &&
                 (wptrQ[ADDR_W-1:0] == rptrQ[ADDR_W-1:0]);
  assign empty = (wptrQ == rptrQ);

  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = rdDataQ;
  assign level    = wptrQ - rptrQ;
  assign rdCnt    = rdCntQ;
  assign wrCnt    = wrCntQ;

  assign push  = wr_valid && !full;
  assign pop   = !empty && rd_ready;
  assign ramWe = push && !flush;

  gfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ramWe),
    .waddr_i(wptrQ[ADDR_W-1:0]),
    .wdata_i(wr_data),
    .raddr_i(rptrD[ADDR_W-1:0]),
    .rdata_o(ramRdata)
  );

  always_comb begin
    wptrD  = wptrQ;
    rptrD  = rptrQ;
    rdCntD = rdCntQ;
    wrCntD = wrCntQ;
    if (flush) begin
      wptrD = '0;
      rptrD = '0;
    end else begin
      if (push) begin
        wptrD  = wptrQ + LVL_W'(1);
        wrCntD = wrCntQ + CNT_W'(1);
      end
      if (pop) begin
        rptrD  = rptrQ + LVL_W'(1);
        rdCntD = rdCntQ + CNT_W'(1);
      end
    end
  end

  // The next head is the word being written this edge when it lands exactly at the new read pointer.
  always_comb begin
    rdDataD = ramRdata;
    if (wptrD == rptrD) begin
      rdDataD = '0;
    end else if (push && (rptrD[ADDR_W-1:0] == wptrQ[ADDR_W-1:0])) begin
      rdDataD = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptrQ   <= '0;
      rptrQ   <= '0;
      rdCntQ  <= '0;
      wrCntQ  <= '0;
      rdDataQ <= '0;
    end else begin
      wptrQ   <= wptrD;
      rptrQ   <= rptrD;
      rdCntQ  <= rdCntD;
      wrCntQ  <= wrCntD;
      rdDataQ <= rdDataD;
    end
  end

endmodule
